// File: rtl/two_phase_deserializer.sv
// Receive-side deserializer for a two-phase (toggle) request/acknowledge bit stream in the clkB domain.
// Assembles WIDTH bits into a word on a valid/ready output and withholds AckB while that word cannot be delivered.
module two_phase_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clkB,
    input  logic                       rstB_n,
    input  logic                       ReqB,
    input  logic                       DataB,
    output logic                       AckB,
    input  logic                       Flush,
    output logic [WIDTH-1:0]           WordOut,
    output logic                       WordValid,
    input  logic                       WordReady,
    output logic [$clog2(WIDTH+1)-1:0] BitCnt,
    output logic                       ProtoErr
);

    localparam int CNT_W = $clog2(WIDTH+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACK   = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_STALL = 2'd3;

    logic [1:0]       r_state;
    logic             r_req_q;
    logic             r_ack;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_perr;

    logic w_evt;
    logic w_accept;
    logic w_last;

    // Shifting in from one end is equivalent to indexing by BitCnt once the word is complete.
    function automatic logic [WIDTH-1:0] f_insert(input logic [WIDTH-1:0] sr, input logic b);
        if (MSB_FIRST)
            return {sr[WIDTH-2:0], b};
        else
            return {b, sr[WIDTH-1:1]};
    endfunction

    assign w_evt    = (ReqB != r_req_q);
    assign w_accept = r_valid && WordReady;
    assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clkB or negedge rstB_n) begin
        if (!rstB_n) begin
            r_state <= S_IDLE;
            r_req_q <= 1'b0;
            r_ack   <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_req_q <= ReqB;
            if (w_accept)
                r_valid <= 1'b0;
            // A new request before the previous acknowledge is a sender fault; the bit is ignored.
            if (w_evt && (r_state != S_IDLE))
                r_perr <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (Flush) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        if (w_evt)
                            r_state <= S_ACK;
                    end else if (w_evt) begin
                        r_shift <= f_insert(r_shift, DataB);
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (!w_last)
                            r_state <= S_ACK;
                        else if (!r_valid || w_accept)
                            r_state <= S_LOAD;
                        else
                            r_state <= S_STALL;
                    end
                end
                S_ACK: begin
                    r_ack   <= ~r_ack;
                    r_state <= S_IDLE;
                    if (Flush) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    r_word  <= r_shift;
                    r_valid <= 1'b1;
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_ack   <= ~r_ack;
                    r_state <= S_IDLE;
                end
                S_STALL: begin
                    // Dropping the held word still acknowledges its last bit.
                    if (Flush) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ACK;
                    end else if (w_accept) begin
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AckB      = r_ack;
    assign WordOut   = r_word;
    assign WordValid = r_valid;
    assign BitCnt    = r_cnt;
    assign ProtoErr  = r_perr;

endmodule

// File: tb/tb_two_phase_deserializer.sv
// Directed bench for two_phase_deserializer: one MSB-first and one LSB-first instance, WIDTH=8.
module tb_two_phase_deserializer;

    logic       clk;
    logic       rst_n;

    logic       req0, data0, ack0, flush0, valid0, ready0, perr0;
    logic [7:0] word0;
    logic [3:0] cnt0;

    logic       req1, data1, ack1, flush1, valid1, ready1, perr1;
    logic [7:0] word1;
    logic [3:0] cnt1;

    logic       exp0, exp1;
    int         compared;
    int         mismatched;

    two_phase_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clkB(clk), .rstB_n(rst_n), .ReqB(req0), .DataB(data0), .AckB(ack0),
        .Flush(flush0), .WordOut(word0), .WordValid(valid0), .WordReady(ready0),
        .BitCnt(cnt0), .ProtoErr(perr0)
    );

    two_phase_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clkB(clk), .rstB_n(rst_n), .ReqB(req1), .DataB(data1), .AckB(ack1),
        .Flush(flush1), .WordOut(word1), .WordValid(valid1), .WordReady(ready1),
        .BitCnt(cnt1), .ProtoErr(perr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit per handshake; AckB must hold for one edge and toggle on the second.
    task automatic send_bit(input bit sel, input logic b, input logic fl);
        logic e;
        logic a;
        if (!sel) begin
            data0 = b; req0 = ~req0; exp0 = ~exp0; flush0 = fl;
        end else begin
            data1 = b; req1 = ~req1; exp1 = ~exp1;
        end
        tick();
        flush0 = 1'b0;
        e = sel ? exp1 : exp0;
        a = sel ? ack1 : ack0;
        compared++;
        if (a !== ~e) begin
            mismatched++;
            $display("FAIL ack_early sel=%0d: AckB=%b, required %b", sel, a, ~e);
        end
        tick();
        a = sel ? ack1 : ack0;
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL ack_latency sel=%0d: AckB=%b, required %b", sel, a, e);
        end
    endtask

    task automatic send_word(input bit sel, input logic [7:0] w, input bit msb);
        for (int i = 0; i < 8; i++)
            send_bit(sel, msb ? w[7-i] : w[i], 1'b0);
    endtask

    task automatic test_reset();
        compared++;
        if ({ack0, cnt0, valid0, perr0, word0} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_state: ack/cnt/valid/perr/word=%b/%0d/%b/%b/%h, required 0/0/0/0/00",
                     ack0, cnt0, valid0, perr0, word0);
        end
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        compared++;
        if (cnt0 !== 4'd3) begin
            mismatched++;
            $display("FAIL pre_reset_cnt: BitCnt=%0d, required 3", cnt0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({ack0, cnt0, valid0, perr0} !== 7'd0) begin
            mismatched++;
            $display("FAIL async_reset: ack/cnt/valid/perr=%b/%0d/%b/%b, required 0/0/0/0",
                     ack0, cnt0, valid0, perr0);
        end
        req0 = 1'b0; data0 = 1'b0; exp0 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_msb();
        ready0 = 1'b1;
        send_word(0, 8'hB2, 1'b1);
        compared++;
        if (valid0 !== 1'b1 || word0 !== 8'hB2) begin
            mismatched++;
            $display("FAIL word_msb: valid=%b word=%h, required 1 b2", valid0, word0);
        end
        tick();
        compared++;
        if (valid0 !== 1'b0 || cnt0 !== 4'd0) begin
            mismatched++;
            $display("FAIL valid_pulse: valid=%b cnt=%0d, required 0 0", valid0, cnt0);
        end
    endtask

    task automatic test_backpressure();
        ready0 = 1'b0;
        send_word(0, 8'hB2, 1'b1);
        for (int i = 0; i < 7; i++)
            send_bit(0, (8'h5A >> (7 - i)) & 8'h01, 1'b0);
        data0 = 1'b0;
        req0  = ~req0;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (ack0 !== exp0 || valid0 !== 1'b1 || word0 !== 8'hB2) begin
                mismatched++;
                $display("FAIL stall_hold: ack=%b valid=%b word=%h, required %b 1 b2",
                         ack0, valid0, word0, exp0);
            end
        end
        ready0 = 1'b1;
        tick();
        compared++;
        if (ack0 !== exp0) begin
            mismatched++;
            $display("FAIL stall_release_early: ack=%b, required %b", ack0, exp0);
        end
        exp0 = ~exp0;
        tick();
        compared++;
        if (ack0 !== exp0 || valid0 !== 1'b1 || word0 !== 8'h5A) begin
            mismatched++;
            $display("FAIL stall_release: ack=%b valid=%b word=%h, required %b 1 5a",
                     ack0, valid0, word0, exp0);
        end
        tick();
        compared++;
        if (valid0 !== 1'b0 || cnt0 !== 4'd0) begin
            mismatched++;
            $display("FAIL after_release: valid=%b cnt=%0d, required 0 0", valid0, cnt0);
        end
    endtask

    task automatic test_lsb_first();
        ready1 = 1'b1;
        send_word(1, 8'h5A, 1'b0);
        compared++;
        if (valid1 !== 1'b1 || word1 !== 8'h5A) begin
            mismatched++;
            $display("FAIL word_lsb: valid=%b word=%h, required 1 5a", valid1, word1);
        end
    endtask

    task automatic test_flush();
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        compared++;
        if (cnt0 !== 4'd0) begin
            mismatched++;
            $display("FAIL flush_idle: BitCnt=%0d, required 0", cnt0);
        end
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b1);
        compared++;
        if (cnt0 !== 4'd0) begin
            mismatched++;
            $display("FAIL flush_with_bit: BitCnt=%0d, required 0", cnt0);
        end
        send_word(0, 8'hC3, 1'b1);
        compared++;
        if (valid0 !== 1'b1 || word0 !== 8'hC3) begin
            mismatched++;
            $display("FAIL flush_word: valid=%b word=%h, required 1 c3", valid0, word0);
        end
        tick();
    endtask

    task automatic test_proto_err();
        compared++;
        if (perr0 !== 1'b0) begin
            mismatched++;
            $display("FAIL perr_clear: ProtoErr=%b, required 0", perr0);
        end
        data0 = 1'b1;
        req0  = ~req0;
        tick();
        req0  = ~req0;
        exp0  = ~exp0;
        tick();
        compared++;
        if (perr0 !== 1'b1 || cnt0 !== 4'd1 || ack0 !== exp0) begin
            mismatched++;
            $display("FAIL perr_set: perr=%b cnt=%0d ack=%b, required 1 1 %b", perr0, cnt0, ack0, exp0);
        end
        for (int i = 0; i < 3; i++) tick();
        compared++;
        if (perr0 !== 1'b1 || cnt0 !== 4'd1) begin
            mismatched++;
            $display("FAIL perr_sticky: perr=%b cnt=%0d, required 1 1", perr0, cnt0);
        end
        send_bit(0, 1'b0, 1'b0);
        compared++;
        if (perr0 !== 1'b1 || cnt0 !== 4'd2) begin
            mismatched++;
            $display("FAIL perr_after_bit: perr=%b cnt=%0d, required 1 2", perr0, cnt0);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst_n = 1'b0;
        req0 = 1'b0; data0 = 1'b0; flush0 = 1'b0; ready0 = 1'b0; exp0 = 1'b0;
        req1 = 1'b0; data1 = 1'b0; flush1 = 1'b0; ready1 = 1'b0; exp1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_word_msb();
        test_backpressure();
        test_lsb_first();
        test_flush();
        test_proto_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
